lfsr_multi: RTL
===============

// Module: lfsr_multi
// PURPOSE
//  - Parametrised LFSR generator; successor to the fixed 16-bit Fibonacci LFSR.
//  - Adds generic width and polynomial, and a run-time Fibonacci/Galois mode.
//  - Adds 0..MAX_STEPS shifts per clock, seed reload, lock-up recovery, and a period counter with seed-return detect.
//  - Feeds test-pattern and pseudo-random stimulus consumers in the lab designs.
// PARAMETERS
//  WIDTH        16       state width, >=3
//  FIB_TAPS     16'hB400 Fibonacci tap mask; fb = ^(out & FIB_TAPS)
//  GAL_MASK     16'h6801 Galois toggle mask, XORed in when the shifted-out msb is 1
//  RESET_SEED   16'hACE1 state loaded by reset
//  LOCKUP_SEED  16'h0001 nonzero state substituted for an all-zero state
//  MAX_STEPS    4        max shifts per cycle, >=1
//  CNT_W        32       period counter width
// PORTS
//  clk     in   1                   clock, rising edge
//  reset   in   1                   synchronous, active-high reset
//  load    in   1                   load seed this cycle
//  seed    in   WIDTH               value for load
//  enable  in   1                   advance this cycle
//  steps   in   $clog2(MAX_STEPS+1) shifts to apply when enabled; values >MAX_STEPS clamp to MAX_STEPS
//  galois  in   1                   0 = Fibonacci, 1 = Galois; sampled per cycle
//  out     out  WIDTH               current LFSR state (registered)
//  count   out  CNT_W               steps taken since reset/load, wraps modulo 2^CNT_W
//  match   out  1                   one-cycle pulse: state returned to the reference seed
//  lockup  out  1                   sticky: all-zero state was substituted
// BEHAVIOUR
//  - Reset (sync, highest priority):
//    - out = RESET_SEED, ref seed = RESET_SEED, count = 0, match = 0, lockup = 0.
//  - Priority: reset > load > enable. Load ignores enable, steps and galois.
//  - Load:
//    - out = seed, ref = seed, count = 0, match = 0.
//    - If seed == 0: out = LOCKUP_SEED, ref = LOCKUP_SEED, lockup = 1.
//    - Otherwise lockup = 0.
//  - Single step, Fibonacci: out' = {out[W-2:0], ^(out & FIB_TAPS)}.
//  - Single step, Galois: out' = {out[W-2:0], 1'b0} ^ ({W{out[W-1]}} & GAL_MASK).
//  - Enable with steps = n > 0:
//    - out <= step^n(out), all n steps in the same mode; latency 1 cycle.
//    - count <= count + n, wrapping.
//  - Enable with steps == 0, or enable == 0:
//    - Hold out and count; match = 0.
//  - Lock-up check: if the computed next state is all-zero, write LOCKUP_SEED and set lockup.
//    - Reference seed is unchanged.
//  - match:
//    - Registered; 1 in the cycle after an advance whose final state equals ref.
//    - Intermediate states within a multi-step advance are not checked.
//    - Never 1 after load or reset.
//  - Mode change mid-sequence: legal and takes effect on that cycle's advance; count continues.
// STRUCTURE
//  - Package lfsr_pkg:
//    - lfsr_mode_e {LFSR_FIB, LFSR_GAL}
//    - default tap/mask/seed localparams for widths 8, 16 and 32.
//  - Sub-module lfsr_step:
//    - Combinational single shift, parameters WIDTH, FIB_TAPS, GAL_MASK.
//    - Chained MAX_STEPS times by generate; mux selects the chain tap at index clamp(steps).
//  - Top level holds state, ref, count, match, lockup registers and the lock-up substitution.
// TESTING
//  1. Reset, enable=1, steps=1, Fibonacci -> out 0xACE1 then 0x59C3, 0xB387, 0x670F; count 1, 2, 3.
//  2. Reset, enable=1, steps=3 for one cycle -> out 0x670F, count 3, match 0.
//  3. load seed=0x8001, galois=1, steps=1 -> out 0x8001, then 0x6803.
//  4. Reset, then 65535 single Fibonacci steps -> match pulses exactly once, with out=0xACE1 and count=65535.
//  5. load seed=0 -> out 0x0001, lockup=1; then load 0x1234 -> lockup=0, count=0.
//  6. load and enable asserted together -> load wins. Reset and load together -> RESET_SEED.
//     steps=7 (clamped to 4) -> same as steps=4.

Source files
------------

// File: rtl/lfsr_pkg.sv
// LFSR shared types and default polynomial constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lfsr_pkg;

  // Per-cycle shift mode; the galois input maps directly onto this.
  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // 8-bit: Fibonacci taps on bits 7,5,4,3; Galois x^8+x^4+x^3+x^2+1.
  localparam logic [7:0]  LFSR8_FIB_TAPS    = 8'hB8;
  localparam logic [7:0]  LFSR8_GAL_MASK    = 8'h1D;
  localparam logic [7:0]  LFSR8_RESET_SEED  = 8'hE1;
  localparam logic [7:0]  LFSR8_LOCKUP_SEED = 8'h01;

  // 16-bit: the defaults of the original fixed generator.
  localparam logic [15:0] LFSR16_FIB_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR16_GAL_MASK    = 16'h6801;
  localparam logic [15:0] LFSR16_RESET_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR16_LOCKUP_SEED = 16'h0001;

  // 32-bit: Fibonacci taps on bits 31,21,1,0; Galois x^32+x^7+x^6+x^2+1.
  localparam logic [31:0] LFSR32_FIB_TAPS    = 32'h8020_0003;
  localparam logic [31:0] LFSR32_GAL_MASK    = 32'h0000_00C5;
  localparam logic [31:0] LFSR32_RESET_SEED  = 32'hACE1_2468;
  localparam logic [31:0] LFSR32_LOCKUP_SEED = 32'h0000_0001;

endpackage

// File: rtl/lfsr_step.sv
// Single LFSR shift, Fibonacci or Galois, selected per call.
// Latency: combinational.
// Backpressure: none.
// Ports: cur (state in), mode (shift form), nxt (state after one shift).
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(LFSR16_FIB_TAPS),
  parameter logic [WIDTH-1:0] GAL_MASK = WIDTH'(LFSR16_GAL_MASK)
) (
  input  logic [WIDTH-1:0] cur,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = '0;
    if (mode == LFSR_GAL) begin
      // Shift left; the bit falling off the top decides whether the mask toggles.
      nxt = {cur[WIDTH-2:0], 1'b0} ^ ({WIDTH{cur[WIDTH-1]}} & GAL_MASK);
    end else begin
      nxt = {cur[WIDTH-2:0], ^(cur & FIB_TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_multi.sv
// Parametrised multi-step LFSR with seed load, lock-up recovery and period detect.
// Latency: 1 cycle from load/enable to out/count/match.
// Backpressure: none; every enabled cycle advances 0..MAX_STEPS shifts.
// Ports: clk, reset (sync high); load/seed; enable/steps/galois;
//        out (state), count (steps since reset/load), match (back at ref seed),
//        lockup (sticky, all-zero state replaced).
module lfsr_multi
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] FIB_TAPS    = WIDTH'(LFSR16_FIB_TAPS),
  parameter logic [WIDTH-1:0] GAL_MASK    = WIDTH'(LFSR16_GAL_MASK),
  parameter logic [WIDTH-1:0] RESET_SEED  = WIDTH'(LFSR16_RESET_SEED),
  parameter logic [WIDTH-1:0] LOCKUP_SEED = WIDTH'(LFSR16_LOCKUP_SEED),
  parameter int               MAX_STEPS   = 4,
  parameter int               CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [WIDTH-1:0]               seed,
  input  logic                           enable,
  input  logic [$clog2(MAX_STEPS+1)-1:0] steps,
  input  logic                           galois,
  output logic [WIDTH-1:0]               out,
  output logic [CNT_W-1:0]               count,
  output logic                           match,
  output logic                           lockup
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  lfsr_mode_e       mode;
  logic [WIDTH-1:0] chain [MAX_STEPS+1];
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] next_raw;
  logic [WIDTH-1:0] next_state;
  logic             next_zero;
  logic             advance;
  logic [WIDTH-1:0] ref_seed;

  assign mode     = galois ? LFSR_GAL : LFSR_FIB;
  assign chain[0] = out;

  // chain[k] is the state after k shifts in the current mode.
  for (genvar g = 0; g < MAX_STEPS; g++) begin : g_chain
    lfsr_step #(
      .WIDTH    (WIDTH),
      .FIB_TAPS (FIB_TAPS),
      .GAL_MASK (GAL_MASK)
    ) u_step (
      .cur  (chain[g]),
      .mode (mode),
      .nxt  (chain[g+1])
    );
  end

  // Out-of-range step requests saturate at the deepest chain tap.
  always_comb begin
    sel = steps;
    if (steps > SW'(MAX_STEPS)) sel = SW'(MAX_STEPS);
  end

  always_comb begin
    next_raw = out;
    for (int i = 1; i <= MAX_STEPS; i++) begin
      if (sel == SW'(i)) next_raw = chain[i];
    end
  end

  assign advance    = enable && (steps != '0);
  assign next_zero  = (next_raw == '0);
  assign next_state = next_zero ? LOCKUP_SEED : next_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= RESET_SEED;
      ref_seed <= RESET_SEED;
      count    <= '0;
      match    <= 1'b0;
      lockup   <= 1'b0;
    end else if (load) begin
      count <= '0;
      match <= 1'b0;
      if (seed == '0) begin
        out      <= LOCKUP_SEED;
        ref_seed <= LOCKUP_SEED;
        lockup   <= 1'b1;
      end else begin
        out      <= seed;
        ref_seed <= seed;
        lockup   <= 1'b0;
      end
    end else if (advance) begin
      out   <= next_state;
      count <= count + CNT_W'(sel);
      // Only the final state of a multi-shift advance is compared.
      match <= (next_state == ref_seed);
      if (next_zero) lockup <= 1'b1;
    end else begin
      match <= 1'b0;
    end
  end

endmodule
